// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: core request/response handshake plus data RAM port
interface lsu_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_funct3, mem_addr, mem_wdata
    );
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_funct3, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding load/store initiator with misaligned byte splitting
module lsu_mem_ctrl #(
    parameter int MISALIGN_SPLIT = 1
) (
    input logic         clk,
    input logic         reset,
    lsu_mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;
    state_t      state;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, acc;
    logic [1:0]  k;
    logic        legal, mis;
    logic [1:0]  last, kn;
    logic [7:0]  lane;
    logic [31:0] acc_n, nb;
    function automatic logic [31:0] ext(input logic [2:0] f, input logic [31:0] d);
        return f == 3'b000 ? {{24{d[7]}}, d[7:0]} :
               f == 3'b001 ? {{16{d[15]}}, d[15:0]} :
               f == 3'b100 ? {24'b0, d[7:0]} :
               f == 3'b101 ? {16'b0, d[15:0]} : d;
    endfunction
    always_comb begin
        legal = bus.req_we ? bus.req_funct3 inside {3'b000, 3'b001, 3'b010}
                           : bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        mis   = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
        last  = f3[1] ? 2'd3 : 2'd1;
        kn    = k + 2'd1;
        lane  = 8'(bus.mem_rdata >> {bus.mem_addr[1:0], 3'b000});
        acc_n = acc | ({24'b0, lane} << {k, 3'b000});
        nb    = {24'b0, 8'(wdata >> {kn, 3'b000})};
    end
    // mem_* and resp_* are registered so the RAM sees them for the whole access cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            we             <= 1'b0;
            f3             <= 3'b0;
            addr           <= 32'b0;
            wdata          <= 32'b0;
            acc            <= 32'b0;
            k              <= 2'b0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'b0;
            bus.resp_err   <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_funct3 <= 3'b0;
            bus.mem_addr   <= 32'b0;
            bus.mem_wdata  <= 32'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    we            <= bus.req_we;
                    f3            <= bus.req_funct3;
                    addr          <= bus.req_addr;
                    wdata         <= bus.req_wdata;
                    acc           <= 32'b0;
                    k             <= 2'b0;
                    bus.req_ready <= 1'b0;
                    if (!legal || (mis && MISALIGN_SPLIT == 0)) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b1;
                        bus.resp_rdata <= 32'b0;
                    end else begin
                        state          <= mis ? SPLIT : ACCESS;
                        bus.mem_we     <= bus.req_we;
                        bus.mem_addr   <= bus.req_addr;
                        bus.mem_funct3 <= mis ? 3'b000 : (bus.req_we ? bus.req_funct3 : 3'b010);
                        bus.mem_wdata  <= mis ? {24'b0, bus.req_wdata[7:0]} : bus.req_wdata;
                    end
                end
                ACCESS: begin
                    state          <= RESP;
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= we ? 32'b0 : ext(f3, bus.mem_rdata >> {addr[1:0], 3'b000});
                    bus.mem_we     <= 1'b0;
                    bus.mem_funct3 <= 3'b0;
                    bus.mem_addr   <= 32'b0;
                    bus.mem_wdata  <= 32'b0;
                end
                SPLIT: begin
                    acc <= acc_n;
                    if (k == last) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= we ? 32'b0 : ext(f3, acc_n);
                        bus.mem_we     <= 1'b0;
                        bus.mem_addr   <= 32'b0;
                        bus.mem_wdata  <= 32'b0;
                    end else begin
                        k             <= kn;
                        bus.mem_addr  <= bus.mem_addr + 32'd1;
                        bus.mem_wdata <= nb;
                    end
                end
                default: if (bus.resp_ready) begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.resp_rdata <= 32'b0;
                    bus.resp_err   <= 1'b0;
                    bus.req_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: scoreboard bench, split and reject variants side by side
module tb_lsu_mem_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    lsu_mem_ctrl_if a();
    lsu_mem_ctrl_if b();
    lsu_mem_ctrl #(.MISALIGN_SPLIT(1)) u0 (.clk(clk), .reset(rst), .bus(a));
    lsu_mem_ctrl #(.MISALIGN_SPLIT(0)) u1 (.clk(clk), .reset(rst), .bus(b));
    typedef struct {logic [31:0] rdata; logic err; int cyc;} exp_t;
    exp_t qa[$], qb[$], ea, eb;
    bit act_a, act_b;
    int total = 0, bad = 0, cyc = 0, wcnt_a = 0, wcnt_b = 0;
    logic [31:0] wlast;
    logic [7:0] ram [256];
    always_comb a.mem_rdata = {ram[{a.mem_addr[7:2], 2'd3}], ram[{a.mem_addr[7:2], 2'd2}],
                               ram[{a.mem_addr[7:2], 2'd1}], ram[{a.mem_addr[7:2], 2'd0}]};
    assign b.mem_rdata = 32'h0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (b.mem_we) wcnt_b <= wcnt_b + 1;
        if (a.mem_we) begin
            wcnt_a <= wcnt_a + 1;
            wlast  <= a.mem_addr;
            ram[a.mem_addr[7:0]] <= a.mem_wdata[7:0];
            if (a.mem_funct3 != 3'b000) ram[a.mem_addr[7:0] + 8'd1] <= a.mem_wdata[15:8];
            if (a.mem_funct3 == 3'b010) begin
                ram[a.mem_addr[7:0] + 8'd2] <= a.mem_wdata[23:16];
                ram[a.mem_addr[7:0] + 8'd3] <= a.mem_wdata[31:24];
            end
        end
    end
    function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", n, act, exp);
        end
    endfunction
    always @(negedge clk) if (!rst) begin
        if (a.resp_valid) begin
            if (!act_a) begin
                if (qa.size() == 0) chk("a_unexpected_resp", 32'd1, 32'd0);
                else begin
                    ea = qa.pop_front();
                    chk("a_latency", cyc, ea.cyc);
                end
                act_a = 1'b1;
            end
            chk("a_rdata", a.resp_rdata, ea.rdata);
            chk("a_err", {31'b0, a.resp_err}, {31'b0, ea.err});
            chk("a_req_ready_busy", {31'b0, a.req_ready}, 32'd0);
        end else act_a = 1'b0;
    end
    always @(negedge clk) if (!rst) begin
        if (b.resp_valid) begin
            if (!act_b) begin
                if (qb.size() == 0) chk("b_unexpected_resp", 32'd1, 32'd0);
                else begin
                    eb = qb.pop_front();
                    chk("b_latency", cyc, eb.cyc);
                end
                act_b = 1'b1;
            end
            chk("b_rdata", b.resp_rdata, eb.rdata);
            chk("b_err", {31'b0, b.resp_err}, {31'b0, eb.err});
        end else act_b = 1'b0;
    end
    task automatic issue(input int d, input logic we, input logic [2:0] f3, input logic [31:0] ad,
                         input logic [31:0] wd, input logic [31:0] ex, input logic er,
                         input int lat, input int hold);
        int n;
        exp_t e;
        @(negedge clk);
        n = 0;
        while ((d == 0 ? a.req_ready : b.req_ready) !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n == 10) chk("req_ready_timeout", 32'd0, 32'd1);
        e.rdata = ex; e.err = er; e.cyc = cyc + lat;
        if (d == 0) begin
            a.req_valid = 1'b1; a.req_we = we; a.req_funct3 = f3; a.req_addr = ad; a.req_wdata = wd;
            qa.push_back(e);
        end else begin
            b.req_valid = 1'b1; b.req_we = we; b.req_funct3 = f3; b.req_addr = ad; b.req_wdata = wd;
            qb.push_back(e);
        end
        @(posedge clk);
        #1;
        a.req_valid = 1'b0; b.req_valid = 1'b0;
        a.req_addr = 32'hFFFF_FFF0; a.req_wdata = 32'h0BAD_0BAD; a.req_funct3 = 3'b010;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((d == 0 ? a.resp_valid : b.resp_valid) !== 1'b1 && n < 20);
        if (n == 20) chk("resp_timeout", 32'd0, 32'd1);
        repeat (hold) @(negedge clk);
        if (d == 0) a.resp_ready = 1'b1; else b.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        a.resp_ready = 1'b0; b.resp_ready = 1'b0;
    endtask
    task automatic idle_chk(input string n);
        chk({n, "_req_ready"}, {31'b0, a.req_ready}, 32'd1);
        chk({n, "_outs"}, {a.resp_valid, a.resp_err, a.mem_we, a.mem_funct3} , 6'd0);
        chk({n, "_rdata"}, a.resp_rdata, 32'd0);
        chk({n, "_maddr"}, a.mem_addr, 32'd0);
        chk({n, "_mwdata"}, a.mem_wdata, 32'd0);
    endtask
    initial begin
        int w0;
        logic [7:0] s43, s44;
        a.req_valid = 0; a.req_we = 0; a.req_funct3 = 0; a.req_addr = 0; a.req_wdata = 0; a.resp_ready = 0;
        b.req_valid = 0; b.req_we = 0; b.req_funct3 = 0; b.req_addr = 0; b.req_wdata = 0; b.resp_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        idle_chk("reset");
        chk("reset_b", {b.req_ready, b.resp_valid, b.mem_we}, 3'b100);
        w0 = wcnt_a;
        issue(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 0);
        chk("sw_we_cycles", wcnt_a - w0, 1);
        issue(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 0);
        issue(0, 1, 3'b010, 32'h20, 32'h80FF7F01, 32'h0, 0, 2, 0);
        issue(0, 0, 3'b000, 32'h23, 32'h0, 32'hFFFFFF80, 0, 2, 0);
        issue(0, 0, 3'b100, 32'h23, 32'h0, 32'h00000080, 0, 2, 0);
        issue(0, 0, 3'b001, 32'h22, 32'h0, 32'hFFFF80FF, 0, 2, 0);
        issue(0, 0, 3'b101, 32'h20, 32'h0, 32'h00007F01, 0, 2, 0);
        w0 = wcnt_a;
        issue(0, 1, 3'b010, 32'h31, 32'h44332211, 32'h0, 0, 5, 0);
        chk("split_sw_we_cycles", wcnt_a - w0, 4);
        chk("split_sw_bytes", {ram[8'h34], ram[8'h33], ram[8'h32], ram[8'h31]}, 32'h44332211);
        issue(0, 0, 3'b010, 32'h31, 32'h0, 32'h44332211, 0, 5, 0);
        issue(0, 0, 3'b001, 32'h33, 32'h0, 32'h00004433, 0, 3, 0);
        w0 = wcnt_a;
        issue(0, 0, 3'b011, 32'h40, 32'h0, 32'h0, 1, 1, 0);
        issue(0, 1, 3'b100, 32'h40, 32'h12345678, 32'h0, 1, 1, 3);
        chk("illegal_no_write", wcnt_a - w0, 0);
        s43 = ram[8'h43]; s44 = ram[8'h44];
        @(negedge clk);
        a.req_valid = 1; a.req_we = 1; a.req_funct3 = 3'b010; a.req_addr = 32'h41; a.req_wdata = 32'hAABBCCDD;
        @(posedge clk);
        #1 a.req_valid = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        idle_chk("midreset");
        chk("midreset_written", {ram[8'h42], ram[8'h41]}, 16'hCCDD);
        chk("midreset_kept", {ram[8'h44], ram[8'h43]}, {s44, s43});
        chk("midreset_no_pending", qa.size(), 0);
        issue(0, 1, 3'b001, 32'hFFFFFFFF, 32'h1234BEEF, 32'h0, 0, 3, 0);
        chk("wrap_bytes", {ram[8'h00], ram[8'hFF]}, 16'hBEEF);
        chk("wrap_addr", wlast, 32'h0);
        issue(0, 0, 3'b001, 32'hFFFFFFFF, 32'h0, 32'hFFFFBEEF, 0, 3, 0);
        issue(1, 0, 3'b010, 32'h02, 32'h0, 32'h0, 1, 1, 0);
        issue(1, 1, 3'b001, 32'h03, 32'hFFFF, 32'h0, 1, 1, 1);
        issue(1, 0, 3'b101, 32'h01, 32'h0, 32'h0, 1, 1, 0);
        chk("b_no_write", wcnt_b, 0);
        repeat (3) @(negedge clk);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store initiator between the core's memory stage and the byte-addressable data RAM. The data RAM has a combinational read and writes on the clock edge, selecting SB/SH/SW by funct3. This block accepts one load or store request at a time and drives the RAM port. It extracts and sign- or zero-extends load data, and splits misaligned accesses into sequential byte accesses (or reports them as errors). It returns one response per request over a valid/ready handshake.

Parameters:
MISALIGN_SPLIT, 1, 1 = split misaligned accesses into byte accesses; 0 = reject them with resp_err.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32 load/store funct3
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  response present
resp_ready  in  1  response consumed
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned (when MISALIGN_SPLIT=0) or illegal funct3
mem_we  out  1  RAM write enable
mem_funct3  out  3  RAM width select
mem_addr  out  32  RAM byte address
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM word at mem_addr[31:2], combinational

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- On reset: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_we=0; mem_funct3=0; mem_addr=0; mem_wdata=0.
- States: IDLE, ACCESS, SPLIT, RESP.
  - req_ready=1 only in IDLE.
  - A request is accepted at edge T when req_valid and req_ready are both high. addr, we, funct3 and wdata are registered at T.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is illegal: go to RESP with resp_err=1 and resp_rdata=0, no RAM cycle, resp_valid high in cycle T+1.
- Misaligned means: halfword access with addr[0]=1, or word access with addr[1:0]!=0.
  - MISALIGN_SPLIT=0: handled like an illegal funct3 (error, no RAM cycle, response at T+1).
- Aligned access (ACCESS state), one cycle at T+1:
  - mem_addr=addr, mem_funct3=funct3 (stores) or 010 (loads), mem_wdata=wdata, mem_we=we.
  - Load data is captured from mem_rdata at the end of T+1.
  - Extraction: byte lane = addr[1:0], half lane = addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - resp_valid rises at T+2.
- Split access (SPLIT state, MISALIGN_SPLIT=1), N = 2 for halfword, 4 for word:
  - Byte k=0..N-1 is accessed in cycle T+1+k.
  - mem_addr = addr+k, wrapping modulo 2^32. mem_funct3=000.
  - Stores: mem_wdata = {24'b0, wdata[8k+7:8k]}, mem_we=1.
  - Loads: byte lane (addr+k)[1:0] of mem_rdata is captured into assembly bits [8k+7:8k]. The assembled value is extended per funct3 after the last byte.
  - resp_valid rises at T+1+N.
- RESP state:
  - resp_valid, resp_rdata and resp_err are held stable until resp_ready=1. Return to IDLE on the cycle after the handshake.
  - The next request is accepted in the IDLE cycle that follows; no overlap with RESP.
  - resp_rdata=0 for stores.
- mem_we=1 only in ACCESS or SPLIT with a store. Outside those states all mem_* outputs are 0.
- Reset mid-operation: the next edge forces IDLE and deasserts all outputs. Bytes already written by a partial split store stay in RAM and are not rolled back.
- Input changes while busy are ignored; only the registered request is used.

Test Plan:
- Aligned SW addr=0x10, wdata=0xDEADBEEF, then LW addr=0x10 -> mem_we high for exactly 1 cycle; store response at T+2 with resp_rdata=0, resp_err=0; load response resp_rdata=0xDEADBEEF at T+2.
- Word at 0x20 = 0x80FF7F01; LB 0x23 -> 0xFFFFFF80; LBU 0x23 -> 0x00000080; LH 0x22 -> 0xFFFF80FF; LHU 0x20 -> 0x00007F01.
- MISALIGN_SPLIT=1: SW addr=0x31, wdata=0x44332211 -> 4 SB cycles at 0x31..0x34 with low bytes 11,22,33,44; response at T+5. LW 0x31 then returns 0x44332211; LH 0x33 returns 0x00004433 sign-extended (bit 15 = 0).
- MISALIGN_SPLIT=0: LW 0x02 -> resp_err=1, resp_rdata=0, response at T+1, mem_we never asserted.
- Load funct3=011, then store funct3=100 -> resp_err=1, no RAM access; resp_ready held low 3 cycles -> response held stable and req_ready=0 throughout.
- Reset asserted at T+2 of a split SW to 0x41 -> bytes 0x41 and 0x42 written, 0x43 and 0x44 unchanged; after reset all outputs 0 and req_ready=1. Wrap case: SH at 0xFFFFFFFF -> second byte written at 0x00000000.
